// File: rtl/gpio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_pkg : register map and encodings shared by the GPIO block    |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package gpio_pkg;

  localparam int REG_IDX_W = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t GPIO_OUT     = 4'd0;
  localparam reg_idx_t GPIO_DIR     = 4'd1;
  localparam reg_idx_t GPIO_IN      = 4'd2;
  localparam reg_idx_t GPIO_OUT_SET = 4'd3;
  localparam reg_idx_t GPIO_OUT_CLR = 4'd4;
  localparam reg_idx_t GPIO_OUT_TGL = 4'd5;
  localparam reg_idx_t GPIO_RISE_EN = 4'd6;
  localparam reg_idx_t GPIO_FALL_EN = 4'd7;
  localparam reg_idx_t GPIO_STAT    = 4'd8;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/gpio_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_if  : memory-mapped peripheral bus seen by the GPIO block    |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
interface gpio_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [31:0]       di;
  logic [31:0]       dout;

  modport master (output addr, output we, output di, input dout);
  modport slave  (input addr, input we, input di, output dout);
endinterface
`default_nettype wire

// File: rtl/gpio_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_port : one port - registers, input sync, edge detect, pads   |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  reg_idx_t         idx,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] rdata,
  inout  wire  [WIDTH-1:0] pads,
  output logic             irq
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] stat;
  logic [WIDTH-1:0] s1, s2, h;

  logic             wr;
  logic [WIDTH-1:0] rise, fall, event_bits, w1c;

  assign wr         = sel & we;
  assign rise       = s2 & ~h;
  assign fall       = ~s2 & h;
  assign event_bits = (rise & rise_en) | (fall & fall_en);
  assign w1c        = (wr && idx == GPIO_STAT) ? di : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= '0;
      dir_reg <= '0;
      rise_en <= '0;
      fall_en <= '0;
      stat    <= '0;
      s1      <= '0;
      s2      <= '0;
      h       <= '0;
    end else begin
      s1 <= pads;
      s2 <= s1;
      h  <= s2;
      // A new event in the same cycle as a clear keeps the bit set.
      stat <= (stat & ~w1c) | event_bits;
      if (wr) begin
        case (idx)
          GPIO_OUT:     out_reg <= di;
          GPIO_DIR:     dir_reg <= di;
          GPIO_OUT_SET: out_reg <= out_reg | di;
          GPIO_OUT_CLR: out_reg <= out_reg & ~di;
          GPIO_OUT_TGL: out_reg <= out_reg ^ di;
          GPIO_RISE_EN: rise_en <= di;
          GPIO_FALL_EN: fall_en <= di;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      GPIO_OUT:     rdata = out_reg;
      GPIO_DIR:     rdata = dir_reg;
      GPIO_IN:      rdata = s2;
      GPIO_RISE_EN: rdata = rise_en;
      GPIO_FALL_EN: rdata = fall_en;
      GPIO_STAT:    rdata = stat;
      default:      rdata = '0;
    endcase
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign pads[i] = (dir_reg[i] == DIR_OUT) ? out_reg[i] : 1'bz;
    end
  endgenerate

  assign irq = |(stat & (rise_en | fall_en));

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_ctrl : multi-port GPIO controller with edge interrupts       |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  gpio_if.slave                  bus,
  inout  wire  [PORTS*WIDTH-1:0] ports,
  output logic                   irq
);

  localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORT_W-1:0] port_sel;
  reg_idx_t          idx;
  logic [WIDTH-1:0]  rdata [PORTS];
  logic [PORTS-1:0]  port_irq;
  logic [31:0]       dout_mux;
  logic              unused_di;

  assign port_sel  = bus.addr[PORT_W+REG_IDX_W-1:REG_IDX_W];
  assign idx       = bus.addr[REG_IDX_W-1:0];
  assign unused_di = ^bus.di;

  generate
    for (genvar p = 0; p < PORTS; p++) begin : g_port
      gpio_port #(
        .WIDTH (WIDTH)
      ) u_port (
        .clk   (clk),
        .reset (reset),
        .sel   (port_sel == PORT_W'(p)),
        .we    (bus.we),
        .idx   (idx),
        .di    (bus.di[WIDTH-1:0]),
        .rdata (rdata[p]),
        .pads  (ports[p*WIDTH +: WIDTH]),
        .irq   (port_irq[p])
      );
    end
  endgenerate

  // Unpopulated port indices fall through every compare and read as 0.
  always_comb begin
    dout_mux = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (port_sel == PORT_W'(p)) begin
        dout_mux[WIDTH-1:0] = rdata[p];
      end
    end
  end

  assign bus.dout = dout_mux;
  assign irq      = |port_irq;

endmodule
`default_nettype wire
